u409_tack_sequencer: RTL

- Parametrised transfer-termination sequencer for the 68040 local bus in U409. Successor to the fixed-function transfer-ack logic.
- Serves NUM_CH decoded address regions, such as ROM, Agnus space, CIA, RTC, AUTOCONFIG and ATA.
- Per channel: a programmable wait-state count, an optional external-ready qualifier, and a cache-inhibit attribute.
- Adds a bus-error watchdog (TEAn) that the previous block did not have.
- Produces registered TACKn/TBIn/TCIn/TEAn with explicit output enables; the top level owns the tristate pads.

---
 rtl/u409_tack_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/u409_tack_sequencer.sv
// u409_tack_sequencer: 68040 local-bus transfer-termination sequencer.
// Per-channel wait states, optional external-ready qualifier, cache-inhibit
// attribute and a bus-error watchdog. All outputs are registered; the pads
// and their tristate buffers live at the top level.
module u409_tack_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DELAY_W = 4,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                        CLK40,
  input  logic                        RESETn,
  input  logic                        TSn,
  input  logic [NUM_CH-1:0]           CH_SEL,
  input  logic [NUM_CH*DELAY_W-1:0]   CH_DELAY,
  input  logic [NUM_CH-1:0]           CH_EXT,
  input  logic [NUM_CH-1:0]           EXT_RDY,
  input  logic [NUM_CH-1:0]           CH_CI,
  input  logic                        TO_CLR,
  output logic                        TACKn,
  output logic                        TACK_OE,
  output logic                        TBIn,
  output logic                        TCIn,
  output logic                        TEAn,
  output logic                        TEA_OE,
  output logic                        BUSY,
  output logic                        TO_FLAG
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACK    = 3'd2;
  localparam logic [2:0] S_ERR    = 3'd3;
  localparam logic [2:0] S_NEGATE = 3'd4;

  localparam bit              WD_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]         state, state_d;
  logic [CH_W-1:0]    ch, ch_d;
  logic [DELAY_W-1:0] cnt, cnt_d;
  logic               ext, ext_d;
  logic               ci, ci_d;
  logic [TO_W-1:0]    wd, wd_d;

  logic [CH_W-1:0]    sel_ch;
  logic [DELAY_W-1:0] sel_dly;
  logic               sel_ext;
  logic               sel_ci;
  logic               rdy;
  logic               wd_hit;

  logic tackn_d, tack_oe_d, tbin_d, tcin_d, tean_d, tea_oe_d, busy_d, to_flag_d;

  // Lowest-index priority decode of the region select and its attributes
  always_comb begin
    sel_ch  = '0;
    sel_dly = '0;
    sel_ext = 1'b0;
    sel_ci  = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (CH_SEL[i]) begin
        sel_ch  = CH_W'(i);
        sel_dly = CH_DELAY[i*DELAY_W +: DELAY_W];
        sel_ext = CH_EXT[i];
        sel_ci  = CH_CI[i];
      end
    end
  end

  // Termination conditions while waiting; ready takes priority over timeout
  always_comb begin
    rdy    = (cnt == '0) && (!ext || EXT_RDY[ch]);
    wd_hit = WD_EN && (wd == WD_LAST);
  end

  // Next-state and per-transfer context
  always_comb begin
    state_d = state;
    ch_d    = ch;
    cnt_d   = cnt;
    ext_d   = ext;
    ci_d    = ci;
    wd_d    = wd;
    case (state)
      S_IDLE: begin
        if (!TSn && (CH_SEL != '0)) begin
          state_d = S_WAIT;
          ch_d    = sel_ch;
          cnt_d   = sel_dly;
          ext_d   = sel_ext;
          ci_d    = sel_ci;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        if (rdy) begin
          state_d = S_ACK;
        end else if (wd_hit) begin
          state_d = S_ERR;
        end else begin
          cnt_d = (cnt != '0) ? cnt - 1'b1 : cnt;
          wd_d  = wd + 1'b1;
        end
      end
      S_ACK:    state_d = S_NEGATE;
      S_ERR:    state_d = S_NEGATE;
      S_NEGATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs align with state
  always_comb begin
    tackn_d   = (state_d != S_ACK);
    tack_oe_d = (state_d == S_ACK) || ((state_d == S_NEGATE) && TACK_OE);
    tean_d    = (state_d != S_ERR);
    tea_oe_d  = (state_d == S_ERR) || ((state_d == S_NEGATE) && TEA_OE);
    tbin_d    = !((state_d == S_ACK) || (state_d == S_ERR));
    tcin_d    = !((state_d == S_ACK) && ci_d);
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_ERR) begin
      to_flag_d = 1'b1;
    end else if (TO_CLR) begin
      to_flag_d = 1'b0;
    end else begin
      to_flag_d = TO_FLAG;
    end
  end

  // State and context registers
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state <= S_IDLE;
      ch    <= '0;
      cnt   <= '0;
      ext   <= 1'b0;
      ci    <= 1'b0;
      wd    <= '0;
    end else begin
      state <= state_d;
      ch    <= ch_d;
      cnt   <= cnt_d;
      ext   <= ext_d;
      ci    <= ci_d;
      wd    <= wd_d;
    end
  end

  // Registered bus outputs
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      TACKn   <= 1'b1;
      TACK_OE <= 1'b0;
      TBIn    <= 1'b1;
      TCIn    <= 1'b1;
      TEAn    <= 1'b1;
      TEA_OE  <= 1'b0;
      BUSY    <= 1'b0;
      TO_FLAG <= 1'b0;
    end else begin
      TACKn   <= tackn_d;
      TACK_OE <= tack_oe_d;
      TBIn    <= tbin_d;
      TCIn    <= tcin_d;
      TEAn    <= tean_d;
      TEA_OE  <= tea_oe_d;
      BUSY    <= busy_d;
      TO_FLAG <= to_flag_d;
    end
  end

endmodule
